bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3, one bit per clock).
// Values above 9999 saturate to 9999 with overflow set; bcd/overflow only change on done.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] sh_q, sh_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] acc_adj;
  logic [15:0] acc_shift;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [15:0] bcd_q, bcd_d;
  logic        overflow_q, overflow_d;
  logic        done_q, done_d;
  logic        accept;
  logic        last_iter;

  assign accept    = (state_q == IDLE) && start;
  assign last_iter = (state_q == CONV) && (cnt_q == 4'd13);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    if (cnt_q == 4'd13) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: digit adjust, then shift the combined accumulator/shift register
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[14:0], sh_q[13]};

    sh_d       = sh_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    if (accept) begin
      sh_d       = bin;
      acc_d      = '0;
      cnt_d      = '0;
      ovf_pend_d = (bin > 14'd9999);
    end else if (state_q == CONV) begin
      sh_d  = {sh_q[12:0], 1'b0};
      acc_d = acc_shift;
      cnt_d = cnt_q + 4'd1;
      // The accumulator wraps for inputs above 9999, so saturate instead of using it
      if (last_iter) begin
        bcd_d      = ovf_pend_q ? 16'h9999 : acc_shift;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q == CONV);
    done     = done_q;
    bcd      = bcd_q;
    overflow = overflow_q;
  end

endmodule
